cpu_control_seq: RTL and testbench

- Instruction sequencer for the basic 8-bit CPU. It sits directly upstream of the program counter, which it drives through `load_pc`, `inc_pc` and `pc_addin`, and it consumes the counter's `pc_addout`.
- Fetches one instruction word per cycle group from unified memory over a req/ack handshake and holds it in an internal instruction register (IR).
- Decodes a 3-bit opcode plus 5-bit address, then sequences operand read, store, jump, skip and halt.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/cpu_control_seq.sv | 151 +++++++++++++++
 tb/tb_cpu_control_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU.
// Opcode and sequencer state encodings.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    INIT     = 4'd0,
    SETTLE_F = 4'd1,
    FETCH    = 4'd2,
    DECODE   = 4'd3,
    SETTLE_D = 4'd4,
    OPER_RD  = 4'd5,
    OPER_WR  = 4'd6,
    JUMP     = 4'd7,
    SKIP     = 4'd8,
    HALT     = 4'd9
  } seq_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter with timeout compare.
// Counts wait cycles of one request; clears between requests.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ack,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Count cycles spent waiting without ack; any other cycle clears.
  always_comb begin
    cnt_d = 8'd0;
    if (waiting && !ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last allowed wait cycle passed with no ack.
  assign timeout = waiting && !ack && (cnt_q == LAST);

endmodule

// File: rtl/cpu_control_seq.sv
// Instruction sequencer for the 8-bit CPU.
// Fetch/decode/execute FSM driving PC and memory handshake.
module cpu_control_seq #(
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addout,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              acc_zero,
  output logic              load_pc,
  output logic              inc_pc,
  output logic [ADDR_W-1:0] pc_addin,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              load_acc,
  output logic [2:0]        alu_op,
  output logic              halted,
  output logic              mem_err
);

  import cpu_pkg::*;

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ir_d;
  logic              mem_err_q;
  logic              mem_err_d;
  logic              waiting;
  logic              timeout;
  opcode_e           opc;
  logic [ADDR_W-1:0] ir_addr;

  assign opc     = opcode_e'(ir_q[DATA_W-1 -: 3]);
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign waiting = (state_q == FETCH) ||
                   (state_q == OPER_RD) ||
                   (state_q == OPER_WR);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .waiting(waiting),
    .ack    (mem_ack),
    .timeout(timeout)
  );

  // Next state, IR capture and sticky timeout flag.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    mem_err_d = mem_err_q;
    unique case (state_q)
      INIT:     state_d = SETTLE_F;
      SETTLE_F: state_d = FETCH;
      FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end else if (timeout) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end
      end
      DECODE:   state_d = SETTLE_D;
      SETTLE_D: begin
        unique case (opc)
          HLT: state_d = HALT;
          SKZ: state_d = acc_zero ? SKIP : FETCH;
          ADD, AND, XOR, LDA: state_d = OPER_RD;
          STO: state_d = OPER_WR;
          JMP: state_d = JUMP;
          default: state_d = HALT;
        endcase
      end
      OPER_RD, OPER_WR: begin
        if (mem_ack) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d   = HALT;
          mem_err_d = 1'b1;
        end
      end
      JUMP:    state_d = SETTLE_F;
      SKIP:    state_d = SETTLE_F;
      HALT:    state_d = HALT;
      default: state_d = INIT;
    endcase
  end

  // State, IR and error flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= INIT;
      ir_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Output decode from state and IR.
  always_comb begin
    load_pc  = 1'b0;
    inc_pc   = 1'b0;
    pc_addin = '0;
    mem_addr = '0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    load_acc = 1'b0;
    alu_op   = 3'd0;
    halted   = 1'b0;
    unique case (state_q)
      INIT: load_pc = 1'b1;
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_addout;
      end
      DECODE: inc_pc = 1'b1;
      OPER_RD: begin
        mem_rd   = 1'b1;
        mem_addr = ir_addr;
        load_acc = mem_ack;
        alu_op   = mem_ack ? ir_q[DATA_W-1 -: 3] : 3'd0;
      end
      OPER_WR: begin
        mem_wr   = 1'b1;
        mem_addr = ir_addr;
      end
      JUMP: begin
        load_pc  = 1'b1;
        pc_addin = ir_addr;
      end
      SKIP: inc_pc = 1'b1;
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_cpu_control_seq.sv
// Directed bench for cpu_control_seq.
// Models PC and memory; checks cycle-exact outputs.
module tb_cpu_control_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] pc_addout;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       acc_zero = 1'b0;
  logic       load_pc;
  logic       inc_pc;
  logic [4:0] pc_addin;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_acc;
  logic [2:0] alu_op;
  logic       halted;
  logic       mem_err;

  logic [7:0] mem [32];
  logic [4:0] pc = 5'h1A;
  int         lat = 0;
  logic       hold_wr = 1'b0;
  int         req_cnt = 0;
  int         n_vec = 0;
  int         n_err = 0;

  cpu_control_seq dut (
    .clk      (clk),
    .rst      (rst),
    .pc_addout(pc_addout),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .acc_zero (acc_zero),
    .load_pc  (load_pc),
    .inc_pc   (inc_pc),
    .pc_addin (pc_addin),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .load_acc (load_acc),
    .alu_op   (alu_op),
    .halted   (halted),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  // Program counter model.
  always @(posedge clk) begin
    if (load_pc) pc <= pc_addin;
    else if (inc_pc) pc <= pc + 5'd1;
  end
  assign pc_addout = pc;

  // Memory model: ack after lat wait cycles.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack = (mem_rd || mem_wr) && (req_cnt == lat) &&
                   !(mem_wr && hold_wr);

  always @(posedge clk) begin
    if (!rst) req_cnt <= 0;
    else if ((mem_rd || mem_wr) && !mem_ack) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  // Hold reset two edges; returns at cycle 0 (INIT).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_load_pc", int'(load_pc), 1);
    check("rst_mem_err", int'(mem_err), 0);
    rst = 1'b1;
  endtask

  initial begin
    // Program: LDA 5; ADD 6; STO 7; HLT
    clear_mem();
    mem[0] = 8'hA5;
    mem[1] = 8'h46;
    mem[2] = 8'hC7;
    mem[3] = 8'h00;
    mem[5] = 8'd3;
    mem[6] = 8'd4;
    lat = 0;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        check("c0_load_pc", int'(load_pc), 1);
        check("c0_pc_addin", int'(pc_addin), 0);
        check("c0_mem_rd", int'(mem_rd), 0);
      end
      if (c == 1) check("c1_mem_rd", int'(mem_rd), 0);
      if (c == 2) begin
        check("c2_mem_rd", int'(mem_rd), 1);
        check("c2_mem_addr", int'(mem_addr), 0);
      end
      if (c == 3) check("c3_inc_pc", int'(inc_pc), 1);
      if (c == 5) begin
        check("lda_load_acc", int'(load_acc), 1);
        check("lda_alu_op", int'(alu_op), 5);
        check("lda_addr", int'(mem_addr), 5);
      end
      if (c == 6) check("c6_load_acc", int'(load_acc), 0);
      if (c == 9) begin
        check("add_load_acc", int'(load_acc), 1);
        check("add_alu_op", int'(alu_op), 2);
      end
      if (c == 13) begin
        check("sto_mem_wr", int'(mem_wr), 1);
        check("sto_addr", int'(mem_addr), 7);
        check("sto_mem_rd", int'(mem_rd), 0);
      end
      if (c == 16) check("c16_halted", int'(halted), 0);
      if (c == 17) begin
        check("c17_halted", int'(halted), 1);
        check("c17_mem_err", int'(mem_err), 0);
      end
    end

    // XOR 5; SKZ (not taken); JMP 31; [31] SKZ; fetch wraps to 0
    clear_mem();
    mem[0]  = 8'h85;
    mem[1]  = 8'h20;
    mem[2]  = 8'hFF;
    mem[31] = 8'h20;
    acc_zero = 1'b0;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 9) check("skz_nt_fetch", int'(mem_addr), 2);
      if (c == 12) begin
        check("jmp_load_pc", int'(load_pc), 1);
        check("jmp_pc_addin", int'(pc_addin), 31);
      end
      if (c == 14) begin
        check("jmp_fetch_rd", int'(mem_rd), 1);
        check("jmp_fetch_addr", int'(mem_addr), 31);
      end
      if (c == 17) begin
        check("wrap_fetch_rd", int'(mem_rd), 1);
        check("wrap_fetch_addr", int'(mem_addr), 0);
      end
    end

    // JMP 4; [4] SKZ taken and not taken
    for (int z = 0; z < 2; z++) begin
      clear_mem();
      mem[0] = 8'hE4;
      mem[4] = 8'h20;
      acc_zero = (z == 0);
      do_reset();
      for (int c = 0; c <= 12; c++) begin
        if (c > 0) @(negedge clk);
        if (c == 7) check("skz_fetch_addr", int'(mem_addr), 4);
        if (z == 0 && c == 10) check("skip_inc", int'(inc_pc), 1);
        if (z == 0 && c == 12) begin
          check("skz_t_rd", int'(mem_rd), 1);
          check("skz_t_addr", int'(mem_addr), 6);
        end
        if (z == 1 && c == 10) begin
          check("skz_nt_rd", int'(mem_rd), 1);
          check("skz_nt_addr", int'(mem_addr), 5);
        end
      end
    end

    // Ack on wait cycle 15 completes
    clear_mem();
    mem[0] = 8'hA5;
    lat = 14;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 16) check("to15_rd", int'(mem_rd), 1);
      if (c == 17) begin
        check("to15_inc", int'(inc_pc), 1);
        check("to15_halted", int'(halted), 0);
        check("to15_err", int'(mem_err), 0);
      end
    end

    // No ack within 15 cycles: HALT with mem_err
    lat = 15;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 16) check("to_last_rd", int'(mem_rd), 1);
      if (c == 17) begin
        check("to_halted", int'(halted), 1);
        check("to_mem_err", int'(mem_err), 1);
        check("to_mem_rd", int'(mem_rd), 0);
      end
    end
    lat = 0;
    acc_zero = 1'b1;
    repeat (5) @(negedge clk);
    check("to_sticky_halt", int'(halted), 1);
    check("to_sticky_err", int'(mem_err), 1);
    rst = 1'b0;
    @(negedge clk);
    check("to_clr_err", int'(mem_err), 0);
    check("to_clr_halt", int'(halted), 0);
    check("to_clr_load_pc", int'(load_pc), 1);

    // Reset while OPER_WR waits for ack
    clear_mem();
    mem[0] = 8'hC7;
    lat = 0;
    hold_wr = 1'b1;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 5) check("wr_pend", int'(mem_wr), 1);
      if (c == 6) check("wr_still", int'(mem_wr), 1);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rstwr_mem_wr", int'(mem_wr), 0);
    check("rstwr_load_pc", int'(load_pc), 1);
    rst = 1'b1;
    hold_wr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
